// File: rtl/psg_mixer_pkg.sv
// Shared constants and types for the PSG channel mixer.
// Config word layout is {pan_l, pan_r, gain}; the pan offsets count upward from the gain MSB + 1.
package psg_mixer_pkg;

  localparam int UNITY_GAIN    = 8;
  localparam int GAIN_SHIFT    = 3;
  localparam int CFG_PAN_R_OFS = 0;
  localparam int CFG_PAN_L_OFS = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/psg_mixer_sat.sv
// Saturating clamp from accumulator width down to the output sample width.
module psg_mixer_sat
  import psg_mixer_pkg::*;
#(
  parameter int IN_W  = 15,
  parameter int OUT_W = 12
) (
  input  logic [IN_W-1:0]  acc_i,
  output logic [OUT_W-1:0] sat_o
);

  generate
    if (IN_W > OUT_W) begin : g_clamp
      // Any set bit above the output range means the sum exceeds full scale.
      always_comb begin
        if (|acc_i[IN_W-1:OUT_W]) begin
          sat_o = {OUT_W{1'b1}};
        end else begin
          sat_o = acc_i[OUT_W-1:0];
        end
      end
    end else begin : g_pass
      assign sat_o = OUT_W'(acc_i);
    end
  endgenerate

endmodule

// File: rtl/psg_mixer.sv
// Time-multiplexed stereo mixer for NUM_PSG three-channel PSGs: one channel per cycle
// through a single shared multiplier, then a saturated, registered stereo sample.
module psg_mixer
  import psg_mixer_pkg::*;
#(
  parameter  int NUM_PSG    = 2,
  parameter  int IN_WIDTH   = 8,
  parameter  int OUT_WIDTH  = 12,
  parameter  int GAIN_WIDTH = 4,
  localparam int NCH        = 3 * NUM_PSG,
  localparam int IDXW       = $clog2(NCH),
  localparam int MW         = IN_WIDTH + GAIN_WIDTH,
  localparam int ACCW       = IN_WIDTH + GAIN_WIDTH + IDXW
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample_stb_i,
  input  logic [NCH*IN_WIDTH-1:0] chan_i,
  input  logic                    mute_i,
  input  logic                    cfg_we_i,
  input  logic [IDXW-1:0]         cfg_addr_i,
  input  logic [GAIN_WIDTH+1:0]   cfg_data_i,
  input  logic                    clear_ovr_i,
  output logic [OUT_WIDTH-1:0]    audio_l_o,
  output logic [OUT_WIDTH-1:0]    audio_r_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         idx_q;
  logic [ACCW-1:0]         acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic [OUT_WIDTH-1:0]    audio_l_q, audio_r_q, sat_l_s, sat_r_s;
  logic                    valid_q, overrun_q;
  logic [GAIN_WIDTH-1:0]   gain_q [NCH];
  logic [NCH-1:0]          pan_l_q, pan_r_q;
  logic [NCH*IN_WIDTH-1:0] snap_chan_q;
  logic [GAIN_WIDTH-1:0]   snap_gain_q [NCH];
  logic [NCH-1:0]          snap_pan_l_q, snap_pan_r_q;
  logic                    snap_mute_q;
  logic                    busy_s, last_s, start_s, drop_s;
  logic [MW-1:0]           mult_s, term_s;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_stb_i) state_d = ST_ACCUM;
        else              state_d = ST_IDLE;
      end
      ST_ACCUM: begin
        if (last_s) state_d = ST_IDLE;
        else        state_d = ST_ACCUM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_s = (state_q == ST_ACCUM);
  end

  assign last_s  = busy_s && (idx_q == IDXW'(NCH - 1));
  assign start_s = sample_stb_i && !busy_s;
  assign drop_s  = sample_stb_i && busy_s;

  // Single shared multiplier; operands come from the frame snapshot only.
  assign mult_s = MW'(snap_chan_q[idx_q*IN_WIDTH +: IN_WIDTH]) * MW'(snap_gain_q[idx_q]);
  assign term_s = mult_s >> GAIN_SHIFT;

  // Accumulator next values including the current channel's term
  always_comb begin
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (snap_pan_l_q[idx_q]) acc_l_d = acc_l_q + ACCW'(term_s);
    else                     acc_l_d = acc_l_q;
    if (snap_pan_r_q[idx_q]) acc_r_d = acc_r_q + ACCW'(term_s);
    else                     acc_r_d = acc_r_q;
  end

  psg_mixer_sat #(.IN_W(ACCW), .OUT_W(OUT_WIDTH)) u_sat_l (.acc_i(acc_l_d), .sat_o(sat_l_s));
  psg_mixer_sat #(.IN_W(ACCW), .OUT_W(OUT_WIDTH)) u_sat_r (.acc_i(acc_r_d), .sat_o(sat_r_s));

  // Live config registers; reset reproduces the even-left / odd-right PSG split.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        gain_q[c]  <= GAIN_WIDTH'(UNITY_GAIN);
        pan_l_q[c] <= ((c / 3) % 2 == 0);
        pan_r_q[c] <= ((c / 3) % 2 != 0);
      end
    end else if (cfg_we_i && (32'(cfg_addr_i) < 32'(NCH))) begin
      gain_q[cfg_addr_i]  <= cfg_data_i[GAIN_WIDTH-1:0];
      pan_r_q[cfg_addr_i] <= cfg_data_i[GAIN_WIDTH+CFG_PAN_R_OFS];
      pan_l_q[cfg_addr_i] <= cfg_data_i[GAIN_WIDTH+CFG_PAN_L_OFS];
    end
  end

  // Frame snapshot, taken before any same-cycle config write lands
  always_ff @(posedge clock) begin
    if (start_s) begin
      snap_chan_q  <= chan_i;
      snap_gain_q  <= gain_q;
      snap_pan_l_q <= pan_l_q;
      snap_pan_r_q <= pan_r_q;
      snap_mute_q  <= mute_i;
    end
  end

  // Accumulation, output load and overrun tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_s) begin
        idx_q   <= '0;
        acc_l_q <= '0;
        acc_r_q <= '0;
      end else if (busy_s) begin
        idx_q   <= idx_q + IDXW'(1);
        acc_l_q <= acc_l_d;
        acc_r_q <= acc_r_d;
        if (last_s) begin
          audio_l_q <= snap_mute_q ? '0 : sat_l_s;
          audio_r_q <= snap_mute_q ? '0 : sat_r_s;
          valid_q   <= 1'b1;
        end
      end
      if (drop_s)           overrun_q <= 1'b1;
      else if (clear_ovr_i) overrun_q <= 1'b0;
    end
  end

  assign audio_l_o = audio_l_q;
  assign audio_r_o = audio_r_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_s;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_psg_mixer.sv
// Self-checking bench: directed table, hand sequences for overrun/reset/saturation, and
// randomized frames scored against a per-channel arithmetic reference model.
module tb_psg_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stb = 1'b0, mute = 1'b0, cfg_we = 1'b0, clr = 1'b0;
  logic [47:0] chan = '0;
  logic [2:0]  cfg_addr = '0;
  logic [5:0]  cfg_data = '0;
  logic [11:0] aud_l, aud_r;
  logic        valid, busy, ovr;

  logic        stb4 = 1'b0, we4 = 1'b0;
  logic [95:0] chan4 = '0;
  logic [3:0]  addr4 = '0;
  logic [5:0]  data4 = '0;
  logic [11:0] l4, r4;
  logic        valid4, busy4, ovr4;

  int n_checks = 0, n_fail = 0;
  int g_m [6];
  bit pl_m [6], pr_m [6];

  always #5 clk = ~clk;

  psg_mixer dut (
    .clock(clk), .reset(reset), .sample_stb_i(stb), .chan_i(chan), .mute_i(mute),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .clear_ovr_i(clr),
    .audio_l_o(aud_l), .audio_r_o(aud_r), .valid_o(valid), .busy_o(busy), .overrun_o(ovr)
  );

  psg_mixer #(.NUM_PSG(4)) dut4 (
    .clock(clk), .reset(reset), .sample_stb_i(stb4), .chan_i(chan4), .mute_i(1'b0),
    .cfg_we_i(we4), .cfg_addr_i(addr4), .cfg_data_i(data4), .clear_ovr_i(clr),
    .audio_l_o(l4), .audio_r_o(r4), .valid_o(valid4), .busy_o(busy4), .overrun_o(ovr4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 6; c++) begin
      g_m[c]  = 8;
      pl_m[c] = ((c / 3) % 2 == 0);
      pr_m[c] = !pl_m[c];
    end
  endfunction

  function automatic void model_write(input int a, input logic [5:0] d);
    if (a < 6) begin
      g_m[a]  = int'(d[3:0]);
      pl_m[a] = d[5];
      pr_m[a] = d[4];
    end
  endfunction

  // Expected one-side sample: sum of scaled panned channels, clamped to 12 bits.
  function automatic int model_side(input logic [47:0] ch, input bit left, input bit m);
    int sum = 0;
    for (int c = 0; c < 6; c++) begin
      int v = int'(ch[c*8 +: 8]);
      int t = (v * g_m[c]) / 8;
      if (left ? pl_m[c] : pr_m[c]) sum += t;
    end
    if (m) return 0;
    return (sum > 4095) ? 4095 : sum;
  endfunction

  // One frame on the default DUT with an optional config write in the strobe cycle.
  task automatic frame(input string nm, input logic [47:0] ch, input bit m, input bit we,
                       input logic [2:0] a, input logic [5:0] d, input int el, input int er);
    int n;
    chan = ch; mute = m; cfg_we = we; cfg_addr = a; cfg_data = d; stb = 1'b1;
    tick();
    stb = 1'b0; cfg_we = 1'b0; mute = 1'b0;
    if (we) model_write(int'(a), d);
    check({nm, " busy"}, int'(busy), 1);
    n = 1;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    check({nm, " latency"}, n, 7);
    check({nm, " left"}, int'(aud_l), el);
    check({nm, " right"}, int'(aud_r), er);
    tick();
    check({nm, " valid pulse"}, int'(valid), 0);
    check({nm, " hold"}, int'(aud_l), el);
  endtask

  typedef struct {
    logic [47:0] ch;
    bit          m;
    bit          we;
    logic [2:0]  a;
    logic [5:0]  d;
    int          el;
    int          er;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int nv, n;
    logic [47:0] rch;
    bit rm, rwe;
    logic [2:0] ra;
    logic [5:0] rd;
    int el, er;

    vecs[0] = '{{6{8'd255}}, 1'b0, 1'b0, 3'd0, 6'd0, 765, 765};
    vecs[1] = '{{6{8'd0}}, 1'b0, 1'b0, 3'd0, 6'd0, 0, 0};
    vecs[2] = '{{8'd30, 8'd20, 8'd10, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b0, 3'd0, 6'd0, 6, 60};
    vecs[3] = '{{6{8'd255}}, 1'b1, 1'b0, 3'd0, 6'd0, 0, 0};
    vecs[4] = '{{6{8'd100}}, 1'b0, 1'b1, 3'd0, 6'b10_0000, 300, 300};
    vecs[5] = '{{6{8'd100}}, 1'b0, 1'b0, 3'd0, 6'd0, 200, 300};
    vecs[6] = '{{6{8'd100}}, 1'b0, 1'b1, 3'd6, 6'b11_1111, 200, 300};
    vecs[7] = '{{6{8'd100}}, 1'b0, 1'b0, 3'd0, 6'd0, 200, 300};
    vecs[8] = '{{6{8'd100}}, 1'b0, 1'b1, 3'd0, 6'b11_1111, 200, 300};
    vecs[9] = '{{6{8'd100}}, 1'b0, 1'b0, 3'd0, 6'd0, 387, 487};

    model_reset();
    tick();
    tick();
    reset = 1'b0;
    check("reset left", int'(aud_l), 0);
    check("reset right", int'(aud_r), 0);
    check("reset valid", int'(valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(ovr), 0);

    for (int i = 0; i < 10; i++) begin
      frame($sformatf("vec%0d", i), vecs[i].ch, vecs[i].m, vecs[i].we, vecs[i].a, vecs[i].d,
            vecs[i].el, vecs[i].er);
    end

    // Strobe dropped mid-frame: sticky overrun, a single output sample.
    stb = 1'b1; tick(); stb = 1'b0;
    tick(); tick();
    stb = 1'b1; tick(); stb = 1'b0;
    check("ovr mid-frame", int'(ovr), 1);
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (valid) nv++;
    end
    check("ovr single valid", nv, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovr cleared", int'(ovr), 0);

    // Strobe on the last ACCUM cycle is dropped and beats a simultaneous clear.
    stb = 1'b1; tick(); stb = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    stb = 1'b1; clr = 1'b1; tick(); stb = 1'b0; clr = 1'b0;
    check("last-cycle valid", int'(valid), 1);
    check("last-cycle drop busy", int'(busy), 0);
    check("drop beats clear", int'(ovr), 1);
    tick();
    check("no restart", int'(busy), 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovr cleared again", int'(ovr), 0);

    // Randomized frames with idle and strobe-cycle config writes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        ra = 3'($urandom_range(0, 7));
        rd = 6'($urandom);
        cfg_we = 1'b1; cfg_addr = ra; cfg_data = rd;
        tick();
        cfg_we = 1'b0;
        model_write(int'(ra), rd);
      end
      rch[31:0]  = $urandom;
      rch[47:32] = 16'($urandom);
      rm  = ($urandom_range(0, 7) == 0);
      rwe = ($urandom_range(0, 1) == 1);
      ra  = 3'($urandom_range(0, 7));
      rd  = 6'($urandom);
      el  = model_side(rch, 1'b1, rm);
      er  = model_side(rch, 1'b0, rm);
      frame($sformatf("rand%0d", i), rch, rm, rwe, ra, rd, el, er);
    end

    // Reset in cycle 3 of a frame aborts it without a valid pulse.
    rch = {6{8'd200}};
    frame("pre-reset", rch, 1'b0, 1'b0, 3'd0, 6'd0,
          model_side(rch, 1'b1, 1'b0), model_side(rch, 1'b0, 1'b0));
    chan = {6{8'd50}};
    stb = 1'b1; tick(); stb = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    check("abort left", int'(aud_l), 0);
    check("abort right", int'(aud_r), 0);
    check("abort busy", int'(busy), 0);
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (valid) nv++;
    end
    check("abort no valid", nv, 0);
    frame("post-reset", {6{8'd255}}, 1'b0, 1'b0, 3'd0, 6'd0, 765, 765);

    // Four PSGs, full gain on both sides: saturation, then an in-range sum.
    for (int c = 0; c < 12; c++) begin
      we4 = 1'b1; addr4 = 4'(c); data4 = 6'b11_1111;
      tick();
    end
    we4 = 1'b0;
    chan4 = {12{8'd255}};
    stb4 = 1'b1; tick(); stb4 = 1'b0;
    n = 1;
    while (!valid4 && n < 30) begin
      tick();
      n++;
    end
    check("psg4 latency", n, 13);
    check("psg4 sat left", int'(l4), 4095);
    check("psg4 sat right", int'(r4), 4095);
    chan4 = {12{8'd10}};
    tick();
    stb4 = 1'b1; tick(); stb4 = 1'b0;
    n = 1;
    while (!valid4 && n < 30) begin
      tick();
      n++;
    end
    check("psg4 latency2", n, 13);
    check("psg4 left", int'(l4), 216);
    check("psg4 right", int'(r4), 216);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/psg_mixer.md
PSG_MIXER -- requirements
Module: psg_mixer

Interface
REQ-001 SHALL have parameter NUM_PSG, default 2: number of 3-channel PSGs mixed (1..8); NCH = 3*NUM_PSG.
REQ-002 SHALL have parameter IN_WIDTH, default 8: unsigned channel sample width.
REQ-003 SHALL have parameter OUT_WIDTH, default 12: unsigned output sample width per side.
REQ-004 SHALL have parameter GAIN_WIDTH, default 4: per-channel gain width; gain value 8 is unity.
REQ-005 SHALL have one clock and a synchronous, active-high reset, as the following two ports.
REQ-006 clock  in  1  system logic clock; all state on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 sample_stb_i  in  1  one-cycle frame start, typically phi1_negedge rate.
REQ-009 chan_i  in  NCH*IN_WIDTH  channel samples; channel c at bits [c*IN_WIDTH +: IN_WIDTH], PSG p owns c = 3p..3p+2.
REQ-010 mute_i  in  1  frame mixes to zero when high at frame start.
REQ-011 cfg_we_i  in  1  config write strobe.
REQ-012 cfg_addr_i  in  clog2(NCH)  channel index to write.
REQ-013 cfg_data_i  in  GAIN_WIDTH+2  {pan_l, pan_r, gain}.
REQ-014 clear_ovr_i  in  1  clears overrun_o.
REQ-015 audio_l_o / audio_r_o  out  OUT_WIDTH each  registered mixed samples.
REQ-016 valid_o  out  1  one-cycle pulse when audio outputs update.
REQ-017 busy_o  out  1  high while a frame is being accumulated.
REQ-018 overrun_o  out  1  sticky: a strobe was dropped.

Function
REQ-019 SHALL use a two-state FSM, IDLE and ACCUM, with channel index idx.
REQ-020 In IDLE, sample_stb_i SHALL snapshot chan_i, all config registers and mute_i.
REQ-021 The same strobe SHALL clear both accumulators, set idx=0 and enter ACCUM.
REQ-022 Each ACCUM cycle SHALL compute term = (snap[idx]*gain[idx]) >> 3.
REQ-023 Each ACCUM cycle SHALL add term to acc_l if pan_l[idx] and to acc_r if pan_r[idx], then increment idx.
REQ-024 The accumulators SHALL be IN_WIDTH+GAIN_WIDTH+clog2(NCH) bits wide and SHALL never wrap.
REQ-025 On the ACCUM cycle with idx==NCH-1, the next edge SHALL load audio_l_o/audio_r_o with accumulators (including that term) saturated to 2^OUT_WIDTH-1.
REQ-026 On that same edge, valid_o SHALL pulse and the FSM SHALL return to IDLE.
REQ-027 Latency: strobe in cycle 0 -> valid_o high in cycle NCH+1; audio outputs hold between frames.
REQ-028 When the snapshotted mute is high, the frame SHALL still take NCH cycles and SHALL output 0/0 with valid_o.
REQ-029 busy_o SHALL equal (state==ACCUM).
REQ-030 sample_stb_i while busy_o (including the last ACCUM cycle) SHALL be ignored and SHALL set overrun_o.
REQ-031 clear_ovr_i SHALL clear overrun_o; a simultaneous dropped strobe SHALL win (overrun_o stays 1).
REQ-032 A cfg write SHALL update its register on the next edge at any time; an in-flight frame SHALL use only its snapshot.
REQ-033 A cfg write with cfg_addr_i >= NCH SHALL be ignored.
REQ-034 A write and a strobe in the same cycle SHALL snapshot the pre-write value.

Reset
REQ-035 Reset SHALL force state=IDLE, idx=0, accumulators=0, audio outputs=0, valid_o=0 and overrun_o=0, aborting any frame without a valid_o pulse.
REQ-036 Reset SHALL set every gain to 8.
REQ-037 Reset SHALL set pan by PSG index: even p {pan_l=1, pan_r=0}; odd p {0,1}. This reproduces the two-PSG Model A left/right split.

Structure
REQ-038 A shared package psg_mixer_pkg SHALL hold the unity-gain constant (8), the gain shift (3), the state enum and the cfg field positions.
REQ-039 One sub-module, psg_mixer_sat, SHALL implement the parametrised saturating accumulator-to-OUT_WIDTH clamp and SHALL be instantiated twice.
REQ-040 The mixer SHALL use one multiplier, shared across channels.

Verification
REQ-041 Defaults (NUM_PSG=2), all channels 255, one strobe -> valid_o in cycle 7 with L=765, R=765.
REQ-042 NUM_PSG=4, all gains 15 and pans {1,1}, all channels 255 -> each side 12*478=5736 saturates to 4095.
REQ-043 Strobe in cycle 0 and again in cycle 3 -> overrun_o=1, one valid_o only; clear_ovr_i -> 0.
REQ-044 Write channel 0 gain=0 in the strobe cycle -> that frame unchanged; the next frame drops channel 0.
REQ-045 Assert reset in cycle 3 of a frame -> no valid_o, outputs 0; the next strobe gives the correct sum.
REQ-046 mute_i=1 at strobe -> valid_o in cycle NCH+1 with 0/0; cfg_addr_i=NCH write -> no register change.
